// File: rtl/oh_pwrsw_seq.sv
// Power-switch sequencer for a gated domain with a segmented footer switch.
// Ramps segments one at a time, settles, releases isolation then reset; reverses on power-down.
module oh_pwrsw_seq #(
    parameter int N      = 4,
    parameter int STAGE  = 8,
    parameter int SETTLE = 16
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic         pwr_req,
    output logic [N-1:0] sw_en,
    output logic         iso_en,
    output logic         dom_nreset,
    output logic         pwr_ack,
    output logic         busy
);
    localparam int MAXC = (STAGE > SETTLE) ? STAGE : SETTLE;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] STG_LAST = CW'(STAGE - 1);
    localparam logic [CW-1:0] SET_LAST = CW'(SETTLE - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(MAXC);
    localparam logic [N-1:0]  ONES     = '1;
    localparam logic [N-1:0]  SEG0     = N'(1);

    typedef enum logic [2:0] {S_OFF, S_UP, S_SETTLE, S_REL, S_ON, S_ISO} state_t;

    typedef struct packed {
        logic [N-1:0] sw;
        logic         iso;
        logic         dnr;
        logic         ack;
        logic         busy;
    } out_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    out_t          out_q, out_d;
    logic          adv;
    logic [N-1:0]  sw_nxt;

    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    assign sw_nxt  = (out_q.sw << 1) | SEG0;

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q    <= S_OFF;
            cnt_q      <= '0;
            out_q.sw   <= '0;
            out_q.iso  <= 1'b1;
            out_q.dnr  <= 1'b0;
            out_q.ack  <= 1'b0;
            out_q.busy <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    // Abort (pwr_req low) takes priority over any counter-driven step.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        adv     = 1'b0;
        case (state_q)
            S_OFF: if (pwr_req) begin
                state_d = (N == 1) ? S_SETTLE : S_UP;
                cnt_d   = '0;
            end
            S_UP: begin
                if (!pwr_req) state_d = S_ISO;
                else if (cnt_q == STG_LAST) begin
                    adv   = 1'b1;
                    cnt_d = '0;
                    if (sw_nxt == ONES) state_d = S_SETTLE;
                end else cnt_d = cnt_inc;
            end
            S_SETTLE: begin
                if (!pwr_req) state_d = S_ISO;
                else if (cnt_q == SET_LAST) begin
                    state_d = S_REL;
                    cnt_d   = '0;
                end else cnt_d = cnt_inc;
            end
            S_REL:   state_d = pwr_req ? S_ON : S_ISO;
            S_ON:    if (!pwr_req) state_d = S_ISO;
            S_ISO:   state_d = S_OFF;
            default: state_d = S_OFF;
        endcase
    end

    always_comb begin
        out_d      = out_q;
        out_d.iso  = 1'b1;
        out_d.dnr  = 1'b0;
        out_d.ack  = 1'b0;
        out_d.busy = (state_d != S_OFF) && (state_d != S_ON);
        case (state_d)
            S_OFF: out_d.sw = '0;
            S_UP, S_SETTLE: begin
                if (state_q == S_OFF) out_d.sw = SEG0;
                else if (adv)         out_d.sw = sw_nxt;
            end
            S_REL: out_d.iso = 1'b0;
            S_ON: begin
                out_d.iso = 1'b0;
                out_d.dnr = 1'b1;
                out_d.ack = 1'b1;
            end
            default: ;
        endcase
    end

    assign sw_en      = out_q.sw;
    assign iso_en     = out_q.iso;
    assign dom_nreset = out_q.dnr;
    assign pwr_ack    = out_q.ack;
    assign busy       = out_q.busy;
endmodule

// File: tb/tb_oh_pwrsw_seq.sv
// Bench for oh_pwrsw_seq: an N=4 and an N=1 instance against a timeline model,
// directed scenarios with literal expectations followed by random pwr_req/nreset traffic.
module tb_oh_pwrsw_seq;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       nreset, req4, req1;
    logic [3:0] sw4;
    logic       iso4, dnr4, ack4, busy4;
    logic [0:0] sw1;
    logic       iso1, dnr1, ack1, busy1;

    oh_pwrsw_seq u4 (.clk(clk), .nreset(nreset), .pwr_req(req4), .sw_en(sw4),
                     .iso_en(iso4), .dom_nreset(dnr4), .pwr_ack(ack4), .busy(busy4));
    oh_pwrsw_seq #(.N(1), .STAGE(1), .SETTLE(1)) u1 (.clk(clk), .nreset(nreset), .pwr_req(req1),
                     .sw_en(sw1), .iso_en(iso1), .dom_nreset(dnr1), .pwr_ack(ack1), .busy(busy1));

    int total = 0, bad = 0, ecnt = 0;

    // Model: mode plus cycles elapsed since the power-up request edge.
    localparam int MO_OFF = 0, MO_UP = 1, MO_ON = 2, MO_ISO = 3;
    int         mmode[2] = '{MO_OFF, MO_OFF};
    int         mt[2]    = '{0, 0};
    logic [3:0] mhold[2] = '{4'h0, 4'h0};
    logic       rr, rq4, rq1;

    function automatic int pn(int i); return (i == 0) ? 4 : 1;  endfunction
    function automatic int ps(int i); return (i == 0) ? 8 : 1;  endfunction
    function automatic int pt(int i); return (i == 0) ? 16 : 1; endfunction
    function automatic int lat(int i); return (pn(i) - 1) * ps(i) + pt(i) + 1; endfunction
    function automatic logic [3:0] therm(int k); return 4'((1 << k) - 1); endfunction

    function automatic logic [3:0] esw(int i);
        int k;
        case (mmode[i])
            MO_UP: begin
                k = mt[i] / ps(i) + 1;
                if (k > pn(i)) k = pn(i);
                return therm(k);
            end
            MO_ON:  return therm(pn(i));
            MO_ISO: return mhold[i];
            default: return 4'h0;
        endcase
    endfunction
    function automatic logic eiso(int i);
        if (mmode[i] == MO_ON) return 1'b0;
        if (mmode[i] == MO_UP) return !(mt[i] >= lat(i) - 1);
        return 1'b1;
    endfunction
    function automatic logic eon(int i);   return mmode[i] == MO_ON; endfunction
    function automatic logic ebusy(int i); return mmode[i] == MO_UP || mmode[i] == MO_ISO; endfunction

    task automatic model_update(input int i, input logic r, input logic q);
        if (!r) mmode[i] = MO_OFF;
        else case (mmode[i])
            MO_OFF: if (q) begin mmode[i] = MO_UP; mt[i] = 0; end
            MO_UP: begin
                if (!q) begin mhold[i] = esw(i); mmode[i] = MO_ISO; end
                else begin
                    mt[i]++;
                    if (mt[i] >= lat(i)) mmode[i] = MO_ON;
                end
            end
            MO_ON: if (!q) begin mhold[i] = therm(pn(i)); mmode[i] = MO_ISO; end
            default: mmode[i] = MO_OFF;
        endcase
    endtask

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s edge=%0d got=%h want=%h", nm, ecnt, act, exp);
        end
    endtask

    task automatic compare_all();
        chk("x4", 4'($isunknown({sw4, iso4, dnr4, ack4, busy4})), 4'h0);
        chk("x1", 4'($isunknown({sw1, iso1, dnr1, ack1, busy1})), 4'h0);
        chk("sw4", sw4, esw(0));
        chk("iso4", 4'(iso4), 4'(eiso(0)));
        chk("dnr4", 4'(dnr4), 4'(eon(0)));
        chk("ack4", 4'(ack4), 4'(eon(0)));
        chk("busy4", 4'(busy4), 4'(ebusy(0)));
        chk("sw1", 4'(sw1), esw(1));
        chk("iso1", 4'(iso1), 4'(eiso(1)));
        chk("dnr1", 4'(dnr1), 4'(eon(1)));
        chk("ack1", 4'(ack1), 4'(eon(1)));
        chk("busy1", 4'(busy1), 4'(ebusy(1)));
        chk("inv4_dnr", 4'(dnr4 && !(!iso4 && sw4 == 4'hf)), 4'h0);
        chk("inv4_iso", 4'(!iso4 && sw4 != 4'hf), 4'h0);
        chk("inv1_dnr", 4'(dnr1 && !(!iso1 && sw1 == 1'b1)), 4'h0);
        chk("inv1_iso", 4'(!iso1 && sw1 != 1'b1), 4'h0);
    endtask

    task automatic step(input logic r, input logic q4, input logic q1);
        nreset = r; req4 = q4; req1 = q1;
        @(posedge clk);
        model_update(0, r, q4);
        model_update(1, r, q1);
        ecnt++;
        #1;
        compare_all();
    endtask

    initial begin
        nreset = 1'b0; req4 = 1'b0; req1 = 1'b0;
        repeat (3) step(0, 0, 0);
        chk("rst_sw", sw4, 4'h0);
        chk("rst_iso", 4'(iso4), 4'h1);
        chk("rst_dnr", 4'(dnr4), 4'h0);
        chk("rst_busy", 4'(busy4), 4'h0);
        step(1, 0, 0);

        // Full power-up on both instances.
        for (int e = 0; e <= 45; e++) begin
            step(1, 1, 1);
            if (e == 0)  begin chk("s1_sw0", sw4, 4'b0001); chk("s5_sw0", 4'(sw1), 4'h1); chk("s1_busy0", 4'(busy4), 4'h1); end
            if (e == 1)  chk("s5_iso1", 4'(iso1), 4'h0);
            if (e == 2)  chk("s5_ack2", 4'(ack1), 4'h1);
            if (e == 7)  chk("s1_sw7", sw4, 4'b0001);
            if (e == 8)  chk("s1_sw8", sw4, 4'b0011);
            if (e == 16) chk("s1_sw16", sw4, 4'b0111);
            if (e == 24) chk("s1_sw24", sw4, 4'b1111);
            if (e == 39) chk("s1_iso39", 4'(iso4), 4'h1);
            if (e == 40) begin chk("s1_iso40", 4'(iso4), 4'h0); chk("s1_ack40", 4'(ack4), 4'h0); chk("s1_busy40", 4'(busy4), 4'h1); end
            if (e == 41) begin chk("s1_dnr41", 4'(dnr4), 4'h1); chk("s1_ack41", 4'(ack4), 4'h1); chk("s1_busy41", 4'(busy4), 4'h0); end
        end

        // Power-down from ON.
        step(1, 0, 0);
        chk("s2_iso", 4'(iso4), 4'h1);
        chk("s2_ack", 4'(ack4), 4'h0);
        chk("s2_sw", sw4, 4'hf);
        step(1, 0, 0);
        chk("s2_sw1", sw4, 4'h0);
        chk("s2_busy1", 4'(busy4), 4'h0);
        step(1, 0, 0);

        // Abort during ramp.
        for (int e = 0; e <= 12; e++) step(1, e < 12, e < 12);
        chk("s3_sw12", sw4, 4'b0011);
        chk("s3_busy12", 4'(busy4), 4'h1);
        step(1, 0, 0);
        chk("s3_sw13", sw4, 4'h0);
        chk("s3_busy13", 4'(busy4), 4'h0);
        step(1, 0, 0);

        // Reset mid-sequence, then restart.
        for (int e = 0; e <= 30; e++) step(e != 30, 1, 1);
        chk("s4_sw30", sw4, 4'h0);
        chk("s4_iso30", 4'(iso4), 4'h1);
        chk("s4_busy30", 4'(busy4), 4'h0);
        for (int e = 0; e <= 41; e++) begin
            step(1, 1, 1);
            if (e == 0)  chk("s4_restart", sw4, 4'b0001);
            if (e == 41) chk("s4_ack", 4'(ack4), 4'h1);
        end

        // Random traffic; N=1 instance toggles every 3 cycles.
        rq4 = 1'b1; rq1 = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            rr = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 29) == 0) rq4 = ~rq4;
            if (c % 3 == 0) rq1 = ~rq1;
            step(rr, rq4, rq1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
